// File: rtl/line_buffer_apb_master.sv
// APB initiator: buffers valid/ready commands in a small FIFO and runs one APB
// SETUP/ACCESS transfer per command, with a pready timeout watchdog.
module line_buffer_apb_master #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_tmo,
  output logic          busy,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  cmd_t          r_mem [FIFO_DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_wptr_vis;
  logic [PW:0]   r_rptr;
  state_t        r_state;
  logic [TW-1:0] r_cnt;

  logic          w_full;
  logic          w_push;
  logic          w_avail;
  logic          w_pop;
  logic          w_tmo_hit;
  logic [TW-1:0] w_cnt_inc;
  cmd_t          w_head;

  assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign cmd_ready = ~w_full & ~preset;
  assign w_push    = cmd_valid & cmd_ready;
  // The FSM sees pushes one cycle late through the delayed write pointer.
  assign w_avail   = (r_wptr_vis != r_rptr);
  assign w_head    = r_mem[r_rptr[PW-1:0]];
  assign w_cnt_inc = r_cnt + TW'(1);
  assign w_tmo_hit = (TIMEOUT != 0) && (w_cnt_inc == TW'(TIMEOUT));
  assign w_pop     = w_avail && ((r_state == S_IDLE) ||
                     ((r_state == S_ACCESS) && (pready || w_tmo_hit)));
  assign busy      = (r_state != S_IDLE) || (r_wptr != r_rptr);

  // Storage has no reset; validity is carried by the pointers.
  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wptr     <= '0;
      r_wptr_vis <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
      r_wptr_vis <= r_wptr;
    end
  end

  // APB transfer FSM with registered bus and response outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_avail) begin
            paddr   <= w_head.addr;
            pwrite  <= w_head.write;
            if (w_head.write) pwdata <= w_head.wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready || w_tmo_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err   <= pready ? pslverr : 1'b1;
            rsp_tmo   <= ~pready;
            penable   <= 1'b0;
            if (w_avail) begin
              paddr   <= w_head.addr;
              pwrite  <= w_head.write;
              if (w_head.write) pwdata <= w_head.wdata;
              r_state <= S_SETUP;
            end else begin
              psel    <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
